calc_arbiter: RTL and testbench

CALC_ARBITER -- requirements
Module: calc_arbiter

---
 rtl/calc_arbiter.sv | 121 ++++++++++++
 tb/tb_calc_arbiter.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/calc_arbiter.sv
// Two-requester front end for a shared combinational calculator.
// Define CALC_ARB_FIXED_PRIORITY_EN for fixed priority (requester 0 wins).
module calc_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic             req1_valid,
  output logic             req0_ready,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [WIDTH-1:0] req0_c,
  input  logic [1:0]       req0_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [WIDTH-1:0] req1_c,
  input  logic [1:0]       req1_op,
  output logic [WIDTH-1:0] calc_a,
  output logic [WIDTH-1:0] calc_b,
  output logic [WIDTH-1:0] calc_c,
  output logic [1:0]       calc_op,
  input  logic [WIDTH-1:0] calc_r,
  input  logic             calc_cout,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_r,
  output logic             rsp_cout,
  output logic             rsp_id,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    EXEC,
    RESP
  } state_t;

  state_t state;
  state_t state_nx;
  logic   gnt_id;
  logic   hs;
  logic   id_q;

`ifdef CALC_ARB_FIXED_PRIORITY_EN
  always_comb begin
    gnt_id = ~req0_valid;
  end
`else
  logic last;

  // On a tie, favour whoever was not granted last.
  always_comb begin
    gnt_id = req1_valid;
    if (req0_valid && req1_valid)
      gnt_id = ~last;
  end

  always_ff @(posedge clk) begin
    if (rst)
      last <= 1'b1;
    else if (hs)
      last <= gnt_id;
  end
`endif

  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (state == IDLE && !rst) begin
      req0_ready = req0_valid & ~gnt_id;
      req1_ready = req1_valid & gnt_id;
    end
  end

  assign hs = req0_ready | req1_ready;

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (req0_valid || req1_valid) state_nx = LOAD;
      LOAD: state_nx = EXEC;
      EXEC: state_nx = RESP;
      RESP: if (rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      calc_a   <= '0;
      calc_b   <= '0;
      calc_c   <= '0;
      calc_op  <= '0;
      id_q     <= 1'b0;
      rsp_r    <= '0;
      rsp_cout <= 1'b0;
    end else begin
      state <= state_nx;
      if (hs) begin
        calc_a  <= gnt_id ? req1_a  : req0_a;
        calc_b  <= gnt_id ? req1_b  : req0_b;
        calc_c  <= gnt_id ? req1_c  : req0_c;
        calc_op <= gnt_id ? req1_op : req0_op;
        id_q    <= gnt_id;
      end
      if (state == EXEC) begin
        rsp_r    <= calc_r;
        rsp_cout <= calc_cout;
      end
    end
  end

  assign rsp_valid = (state == RESP);
  assign busy      = (state != IDLE);
  assign rsp_id    = id_q;

endmodule

// File: tb/tb_calc_arbiter.sv
// Directed bench for calc_arbiter with an adder as the shared calculator.
// Honours CALC_ARB_FIXED_PRIORITY_EN for the tie-break expectations.
module tb_calc_arbiter;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req0_valid = 1'b0, req1_valid = 1'b0;
  logic req0_ready, req1_ready;
  logic [W-1:0] req0_a = '0, req0_b = '0, req0_c = '0;
  logic [W-1:0] req1_a = '0, req1_b = '0, req1_c = '0;
  logic [1:0] req0_op = '0, req1_op = '0;
  logic [W-1:0] calc_a, calc_b, calc_c, calc_r;
  logic [1:0] calc_op;
  logic calc_cout;
  logic rsp_valid, rsp_ready = 1'b0;
  logic [W-1:0] rsp_r;
  logic rsp_cout, rsp_id, busy;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  assign {calc_cout, calc_r} = {1'b0, calc_a} + {1'b0, calc_b};

  calc_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_c(req0_c), .req0_op(req0_op),
    .req1_a(req1_a), .req1_b(req1_b), .req1_c(req1_c), .req1_op(req1_op),
    .calc_a(calc_a), .calc_b(calc_b), .calc_c(calc_c), .calc_op(calc_op),
    .calc_r(calc_r), .calc_cout(calc_cout),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_r(rsp_r), .rsp_cout(rsp_cout), .rsp_id(rsp_id), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  logic exp_id;
  logic [W-1:0] exp_r;
  logic got;
  logic r0_seen;

  initial begin
    // Reset state, ready gated by rst
    req0_valid = 1'b1;
    step();
    step();
    #1;
    chk("rst_ready0", {31'd0, req0_ready}, 0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_rsp_r", {24'd0, rsp_r}, 0);
    chk("rst_rsp_cout", {31'd0, rsp_cout}, 0);
    chk("rst_rsp_id", {31'd0, rsp_id}, 0);
    chk("rst_calc_abc", {8'd0, calc_a, calc_b, calc_c}, 0);
    chk("rst_calc_op", {30'd0, calc_op}, 0);

    // Scenario 1: req0 alone, F0 + 20
    rst = 1'b0;
    req0_a = 8'hF0; req0_b = 8'h20; req0_c = 8'h55; req0_op = 2'd2;
    rsp_ready = 1'b1;
    #1;
    chk("s1_ready0", {31'd0, req0_ready}, 1);
    chk("s1_ready1", {31'd0, req1_ready}, 0);
    step();
    req0_valid = 1'b0;
    #1;
    chk("s1_load_busy", {31'd0, busy}, 1);
    chk("s1_load_ops", {6'd0, calc_op, calc_a, calc_b, calc_c},
        {6'd0, 2'd2, 8'hF0, 8'h20, 8'h55});
    chk("s1_load_rv", {31'd0, rsp_valid}, 0);
    step();
    chk("s1_exec_rv", {31'd0, rsp_valid}, 0);
    step();
    chk("s1_rv", {31'd0, rsp_valid}, 1);
    chk("s1_r", {24'd0, rsp_r}, 32'h10);
    chk("s1_cout", {31'd0, rsp_cout}, 1);
    chk("s1_id", {31'd0, rsp_id}, 0);
    step();
    chk("s1_idle_rv", {31'd0, rsp_valid}, 0);
    chk("s1_idle_busy", {31'd0, busy}, 0);

    // Scenario 2: both held for four operations
    do_reset();
    req0_a = 8'h01; req0_b = 8'h02;
    req1_a = 8'h10; req1_b = 8'h20;
    req0_valid = 1'b1; req1_valid = 1'b1;
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
`ifdef CALC_ARB_FIXED_PRIORITY_EN
      exp_id = 1'b0;
`else
      exp_id = i[0];
`endif
      exp_r = exp_id ? 8'h30 : 8'h03;
      got = 1'b0;
      for (int k = 0; k < 10 && !got; k++) begin
        #1;
        if (req0_ready || req1_ready) got = 1'b1;
        else step();
      end
      chk("s2_grant_seen", {31'd0, got}, 1);
      chk("s2_grant", {30'd0, req1_ready, req0_ready},
          exp_id ? 32'd2 : 32'd1);
      step();
      chk("s2_busy_ready", {30'd0, req1_ready, req0_ready}, 0);
      step();
      step();
      chk("s2_rv", {31'd0, rsp_valid}, 1);
      chk("s2_id", {31'd0, rsp_id}, {31'd0, exp_id});
      chk("s2_r", {24'd0, rsp_r}, {24'd0, exp_r});
      step();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;

    // Scenario 3: req1 with rsp_ready low for five cycles
    do_reset();
    rsp_ready = 1'b0;
    req1_a = 8'h05; req1_b = 8'h03; req1_valid = 1'b1;
    #1;
    chk("s3_ready1", {31'd0, req1_ready}, 1);
    step();
    req1_valid = 1'b0;
    req0_valid = 1'b1;
    step();
    step();
    for (int i = 0; i < 6; i++) begin
      if (i == 5) begin
        rsp_ready = 1'b1;
        req0_valid = 1'b0;
      end
      #1;
      chk("s3_hold_rv", {31'd0, rsp_valid}, 1);
      chk("s3_hold_r", {23'd0, rsp_id, rsp_r}, {23'd0, 1'b1, 8'h08});
      chk("s3_hold_ready", {30'd0, req1_ready, req0_ready}, 0);
      step();
    end
    chk("s3_release_rv", {31'd0, rsp_valid}, 0);

    // Scenario 4: reset pulse in EXEC aborts the operation
    do_reset();
    req0_a = 8'h07; req0_b = 8'h09; req0_valid = 1'b1;
    step();
    req0_valid = 1'b0;
    step();
    rst = 1'b1;
    req1_valid = 1'b1;
    #1;
    chk("s4_rst_ready", {30'd0, req1_ready, req0_ready}, 0);
    step();
    rst = 1'b0;
    req1_valid = 1'b0;
    chk("s4_idle", {29'd0, busy, rsp_valid, rsp_cout}, 0);
    chk("s4_clear", {7'd0, rsp_id, rsp_r, calc_a, calc_b}, 0);
    r0_seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (rsp_valid) r0_seen = 1'b1;
      step();
    end
    chk("s4_no_rsp", {31'd0, r0_seen}, 0);
    req0_a = 8'h01; req0_b = 8'h01; req0_valid = 1'b1;
    step();
    req0_valid = 1'b0;
    step();
    step();
    chk("s4_rv", {31'd0, rsp_valid}, 1);
    chk("s4_r", {24'd0, rsp_r}, 32'h02);
    step();

    // Scenario 5: req0 drops before it could be granted
    rst = 1'b1;
    req0_valid = 1'b1;
    #1;
    chk("s5_rst_ready0", {31'd0, req0_ready}, 0);
    step();
    rst = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b1;
    req1_a = 8'h0A; req1_b = 8'h0B;
    r0_seen = 1'b0;
    #1;
    chk("s5_ready1", {31'd0, req1_ready}, 1);
    for (int i = 0; i < 4; i++) begin
      if (req0_ready) r0_seen = 1'b1;
      step();
      req1_valid = 1'b0;
    end
    chk("s5_ready0_never", {31'd0, r0_seen}, 0);
    chk("s5_id_r", {23'd0, rsp_id, rsp_r}, {23'd0, 1'b1, 8'h15});

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
